fft_frame_ctrl: RTL
===================

# fft_frame_ctrl

Frame sequencer and band-peak extractor for the FFT path. It sits between the ADC bit reader and the decimation-in-time FFT core:
- Gathers `vlen` ADC samples per frame and feeds them to the core with its new-data strobe.
- Waits for the core's output burst and computes a magnitude estimate per bin.
- Reports the peak magnitude in two configurable bin bands (modulation A and B), once per frame.

## Interface
Parameters:
- `datlen`, 12: ADC sample width and FFT real/imag component width.
- `vlen`, 32: FFT length N (bins per frame).
- `vlen_log2`, 5: log2(`vlen`), counter width.
- `band_a_lo`, 3: first bin of band A, inclusive.
- `band_a_hi`, 6: last bin of band A, inclusive.
- `band_b_lo`, 16: first bin of band B, inclusive.
- `band_b_hi`, 19: last bin of band B, inclusive.
- `timeout`, 1024: maximum cycles in WAIT before abort.

Ports:
- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `smp_valid` in 1: single-cycle strobe, new ADC sample on `smp`.
- `smp` in `datlen`: unsigned ADC amplitude.
- `fft_rfd` in 1: FFT core ready for data.
- `fft_nd` out 1: new-data strobe to the core.
- `fft_xn` out 2*`datlen`: core input, `{zeros(datlen), sample}` (imag = 0, real = sample).
- `fft_dv` in 1: core output bin valid.
- `fft_xk` in 2*`datlen`: core output, `{im, re}`, each two's complement.
- `peak_a` out `datlen`: band A peak magnitude.
- `peak_b` out `datlen`: band B peak magnitude.
- `peak_valid` out 1: one-cycle pulse when `peak_a`/`peak_b` update.
- `overrun` out 1: sticky; a sample was dropped.
- `timeout_err` out 1: sticky; the core produced no output within `timeout`.

## Operation
Three states:
- **LOAD**
  - On `smp_valid && fft_rfd`: register `fft_xn = {0, smp}`, pulse `fft_nd` and increment `in_cnt`.
  - On `smp_valid && !fft_rfd`: drop the sample and set `overrun`.
  - When the accepted sample is number `vlen-1`, go to WAIT and clear `in_cnt`.
- **WAIT**
  - Increment `wait_cnt` every cycle.
  - On the first `fft_dv`, process that bin as bin 0 and go to UNLOAD.
  - If `wait_cnt` reaches `timeout-1` with no `fft_dv`: set `timeout_err`, go to LOAD and discard the partial frame. `peak_valid` is not pulsed.
- **UNLOAD**
  - Each `fft_dv` processes the next bin (`out_cnt`). Cycles without `fft_dv` are held; there is no timeout here.
  - After bin `vlen-1`, go to LOAD.

Bin processing:
- `mag = |re| + |im|`, computed at `datlen+1` bits, then saturated to `2**datlen - 1`.
- `|−2**(datlen-1)|` = `2**(datlen-1)` with no wrap.
- Band A running max updates if `band_a_lo <= bin <= band_a_hi` and `mag` > current max. Band B uses its own range. Ties keep the current value.
- Running maxima clear to 0 at the start of each frame (entry to WAIT).

General rules:
- `smp_valid` in WAIT or UNLOAD: the sample is dropped and `overrun` is set.
- `fft_dv` in LOAD: ignored, with no flag.
- `fft_nd` is never asserted outside LOAD.
- On reset:
  - Outputs `fft_nd`=0, `fft_xn`=0, `peak_a`=0, `peak_b`=0, `peak_valid`=0, `overrun`=0, `timeout_err`=0.
  - State LOAD; all counters and running maxima 0.
  - Reset mid-frame discards everything, with no `peak_valid`.
- `rst` takes priority over every other event in the same cycle.

## Timing
- `fft_nd` and `fft_xn` are registered: they are asserted in cycle t+1 for a sample accepted in cycle t.
- Bin `vlen-1` seen with `fft_dv` in cycle t:
  - In t+1, `peak_a`/`peak_b` hold the final maxima, including that bin, and `peak_valid`=1.
  - The state is LOAD in t+1, so a sample accepted in t+1 is frame n+1 sample 0.
- Peak outputs hold their value until the next `peak_valid`.
- WAIT timeout: with no `fft_dv` for `timeout` consecutive WAIT cycles, `timeout_err` rises on the following edge and the state returns to LOAD.
- Sample-to-FFT throughput: one sample per cycle maximum.

## Test plan
- **Reset values:** assert `rst` 2 cycles → all outputs 0, state LOAD. Then send 1 sample → `fft_nd`=1 one cycle later, `fft_xn`={12'h000, sample}.
- **Full frame, band A:** 32 samples accepted with `fft_rfd`=1; model core returns bins with `xk`=0 except bin 4 `{im=-5, re=7}` and bin 17 `{im=3, re=-100}` → `peak_valid` one cycle after bin 31, `peak_a`=12, `peak_b`=103.
- **Saturation:** bin 5 = `{im=-2048, re=-2048}` → `peak_a`=4095. Bin 3 with re=2047, im=0 → 2047, no wrap.
- **Overrun:**
  - `smp_valid` while `fft_rfd`=0 in LOAD → `overrun`=1, `in_cnt` unchanged.
  - `smp_valid` during UNLOAD → `overrun`=1, frame result unaffected.
- **Timeout:** fill a frame, hold `fft_dv`=0 for 1024 cycles → `timeout_err`=1, no `peak_valid`. The next frame completes normally.
- **Reset mid-UNLOAD:** `rst` after bin 10 → no `peak_valid`, peaks 0. The next complete frame reports only its own bins.

Source files
------------

// File: rtl/fft_frame_ctrl_if.sv
// Sample input, FFT core handshake and peak report signals of fft_frame_ctrl.
// master is the controller side; slave is the ADC/core/consumer side.
interface fft_frame_ctrl_if #(
    parameter int datlen = 12
);
    logic                smp_valid;
    logic [datlen-1:0]   smp;
    logic                fft_rfd;
    logic                fft_nd;
    logic [2*datlen-1:0] fft_xn;
    logic                fft_dv;
    logic [2*datlen-1:0] fft_xk;
    logic [datlen-1:0]   peak_a;
    logic [datlen-1:0]   peak_b;
    logic                peak_valid;
    logic                overrun;
    logic                timeout_err;

    modport master (
        input  smp_valid, smp, fft_rfd, fft_dv, fft_xk,
        output fft_nd, fft_xn, peak_a, peak_b, peak_valid, overrun, timeout_err
    );

    modport slave (
        output smp_valid, smp, fft_rfd, fft_dv, fft_xk,
        input  fft_nd, fft_xn, peak_a, peak_b, peak_valid, overrun, timeout_err
    );
endinterface

// File: rtl/fft_frame_ctrl.sv
// Frame sequencer for the FFT core: loads vlen samples, waits for the output
// burst, and reports the per-frame peak |re|+|im| magnitude in two bin bands.
module fft_frame_ctrl #(
    parameter int datlen    = 12,
    parameter int vlen      = 32,
    parameter int vlen_log2 = 5,
    parameter int band_a_lo = 3,
    parameter int band_a_hi = 6,
    parameter int band_b_lo = 16,
    parameter int band_b_hi = 19,
    parameter int timeout   = 1024
) (
    input  logic             clk,
    input  logic             rst,
    fft_frame_ctrl_if.master bus
);
    typedef enum logic [1:0] {S_LOAD, S_WAIT, S_UNLOAD} state_e;

    localparam int WAIT_W = $clog2(timeout);
    localparam logic [vlen_log2-1:0] LAST_BIN  = vlen_log2'(vlen - 1);
    localparam logic [WAIT_W-1:0]    WAIT_LAST = WAIT_W'(timeout - 1);
    localparam logic [vlen_log2-1:0] A_LO = vlen_log2'(band_a_lo);
    localparam logic [vlen_log2-1:0] A_HI = vlen_log2'(band_a_hi);
    localparam logic [vlen_log2-1:0] B_LO = vlen_log2'(band_b_lo);
    localparam logic [vlen_log2-1:0] B_HI = vlen_log2'(band_b_hi);

    state_e                state_q, state_d;
    logic [vlen_log2-1:0]  in_cnt_q, in_cnt_d;
    logic [vlen_log2-1:0]  out_cnt_q, out_cnt_d;
    logic [WAIT_W-1:0]     wait_cnt_q, wait_cnt_d;
    logic [datlen-1:0]     max_a_q, max_a_d, max_b_q, max_b_d;
    logic [datlen-1:0]     peak_a_q, peak_a_d, peak_b_q, peak_b_d;
    logic                  peak_valid_q, peak_valid_d;
    logic                  nd_q, nd_d;
    logic [2*datlen-1:0]   xn_q, xn_d;
    logic                  overrun_q, overrun_d;
    logic                  timeout_err_q, timeout_err_d;

    logic [datlen-1:0]     re_u, im_u, abs_re, abs_im, mag;
    logic [datlen:0]       mag_sum;
    logic [vlen_log2-1:0]  bin;
    logic                  in_a, in_b;
    logic [datlen-1:0]     max_a_upd, max_b_upd;

    // Magnitude of the bin on fft_xk; the negated most-negative value reads
    // back as 2**(datlen-1) when treated as unsigned, so no special case.
    always_comb begin
        re_u      = bus.fft_xk[datlen-1:0];
        im_u      = bus.fft_xk[2*datlen-1:datlen];
        abs_re    = re_u[datlen-1] ? (~re_u + datlen'(1)) : re_u;
        abs_im    = im_u[datlen-1] ? (~im_u + datlen'(1)) : im_u;
        mag_sum   = {1'b0, abs_re} + {1'b0, abs_im};
        mag       = mag_sum[datlen] ? '1 : mag_sum[datlen-1:0];
        bin       = (state_q == S_WAIT) ? '0 : out_cnt_q;
        in_a      = (bin >= A_LO) && (bin <= A_HI);
        in_b      = (bin >= B_LO) && (bin <= B_HI);
        max_a_upd = (in_a && (mag > max_a_q)) ? mag : max_a_q;
        max_b_upd = (in_b && (mag > max_b_q)) ? mag : max_b_q;
    end

    always_comb begin
        // NOTE: every signal gets a default first so no path through the
        // case statement leaves one unassigned and infers a latch.
        state_d       = state_q;
        in_cnt_d      = in_cnt_q;
        out_cnt_d     = out_cnt_q;
        wait_cnt_d    = wait_cnt_q;
        max_a_d       = max_a_q;
        max_b_d       = max_b_q;
        peak_a_d      = peak_a_q;
        peak_b_d      = peak_b_q;
        peak_valid_d  = 1'b0;
        nd_d          = 1'b0;
        xn_d          = xn_q;
        overrun_d     = overrun_q;
        timeout_err_d = timeout_err_q;

        if (bus.smp_valid && ((state_q != S_LOAD) || !bus.fft_rfd)) begin
            overrun_d = 1'b1;
        end

        unique case (state_q)
            S_LOAD: begin
                if (bus.smp_valid && bus.fft_rfd) begin
                    nd_d = 1'b1;
                    xn_d = {{datlen{1'b0}}, bus.smp};
                    if (in_cnt_q == LAST_BIN) begin
                        state_d    = S_WAIT;
                        in_cnt_d   = '0;
                        wait_cnt_d = '0;
                        max_a_d    = '0;
                        max_b_d    = '0;
                    end else begin
                        in_cnt_d = in_cnt_q + vlen_log2'(1);
                    end
                end
            end
            S_WAIT: begin
                wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                if (bus.fft_dv) begin
                    max_a_d   = max_a_upd;
                    max_b_d   = max_b_upd;
                    out_cnt_d = vlen_log2'(1);
                    state_d   = S_UNLOAD;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    timeout_err_d = 1'b1;
                    state_d       = S_LOAD;
                end
            end
            S_UNLOAD: begin
                if (bus.fft_dv) begin
                    max_a_d = max_a_upd;
                    max_b_d = max_b_upd;
                    if (out_cnt_q == LAST_BIN) begin
                        state_d      = S_LOAD;
                        out_cnt_d    = '0;
                        peak_a_d     = max_a_upd;
                        peak_b_d     = max_b_upd;
                        peak_valid_d = 1'b1;
                    end else begin
                        out_cnt_d = out_cnt_q + vlen_log2'(1);
                    end
                end
            end
            default: state_d = S_LOAD;
        endcase
    end

    // rst is tested first so it overrides any event in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_LOAD;
            in_cnt_q      <= '0;
            out_cnt_q     <= '0;
            wait_cnt_q    <= '0;
            max_a_q       <= '0;
            max_b_q       <= '0;
            peak_a_q      <= '0;
            peak_b_q      <= '0;
            peak_valid_q  <= 1'b0;
            nd_q          <= 1'b0;
            xn_q          <= '0;
            overrun_q     <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            in_cnt_q      <= in_cnt_d;
            out_cnt_q     <= out_cnt_d;
            wait_cnt_q    <= wait_cnt_d;
            max_a_q       <= max_a_d;
            max_b_q       <= max_b_d;
            peak_a_q      <= peak_a_d;
            peak_b_q      <= peak_b_d;
            peak_valid_q  <= peak_valid_d;
            nd_q          <= nd_d;
            xn_q          <= xn_d;
            overrun_q     <= overrun_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign bus.fft_nd      = nd_q;
    assign bus.fft_xn      = xn_q;
    assign bus.peak_a      = peak_a_q;
    assign bus.peak_b      = peak_b_q;
    assign bus.peak_valid  = peak_valid_q;
    assign bus.overrun     = overrun_q;
    assign bus.timeout_err = timeout_err_q;
endmodule
